// File: rtl/tx_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tx_fifo_wr_arb
//
// Write-side scheduler for the asynchronous TX FIFO. Two requesters in the
// system-clock domain (16-bit ALU result, 8-bit register-file read data)
// are arbitrated. The granted request is latched into a holding register,
// and its bytes are serialised into the FIFO write port. The block stalls
// while the FIFO reports full.
//
// Optional feature:
//   TX_FIFO_WR_ARB_RR_EN  defined   -> round-robin arbitration on a tie
//                          undefined -> fixed priority, ALU wins a tie
//
// Ports:
//   CLK        in   system / FIFO write clock
//   RST        in   asynchronous active-low reset
//   ALU_VLD    in   ALU result request
//   ALU_OUT    in   ALU result (2*DATA_WIDTH), sent low byte first
//   ALU_ACK    out  one-cycle pulse: ALU request captured
//   RF_VLD     in   register-file read-data request
//   RF_OUT     in   register-file byte (DATA_WIDTH)
//   RF_ACK     out  one-cycle pulse: RF request captured
//   WR_full    in   FIFO full flag from the write-pointer block
//   WR_inc     out  FIFO write strobe (combinational)
//   WR_DATA    out  FIFO write data (DATA_WIDTH)
//   BUSY       out  high whenever the scheduler is not idle
//   dbg_state  out  current FSM state (0 IDLE, 1 SEND_LO, 2 SEND_HI, 3 SEND_RF)
//
// Handshake: a requester raises *_VLD with stable data and holds both
// until it sees *_ACK; it then drops *_VLD. Requests are only sampled in
// IDLE. The FIFO side writes one byte on every clock edge where WR_inc is
// high, and WR_inc is never high while WR_full is high.
// ---------------------------------------------------------------------------
module tx_fifo_wr_arb #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      ALU_VLD,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    output logic                      ALU_ACK,
    input  logic                      RF_VLD,
    input  logic [DATA_WIDTH-1:0]     RF_OUT,
    output logic                      RF_ACK,
    input  logic                      WR_full,
    output logic                      WR_inc,
    output logic [DATA_WIDTH-1:0]     WR_DATA,
    output logic                      BUSY,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2,
        SEND_RF = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [2*DATA_WIDTH-1:0]   hold;
    logic                      grant_alu;
    logic                      grant_rf;
    logic                      take_alu;
    logic                      take_rf;

    // -----------------------------------------------------------------------
    // Arbitration. Only acted upon in IDLE; the loser simply keeps its VLD
    // high and is reconsidered on the next IDLE cycle.
    // -----------------------------------------------------------------------
`ifdef TX_FIFO_WR_ARB_RR_EN
    // High when the most recent grant went to the ALU. Resets to "RF" so
    // the ALU wins the first tie.
    logic last_alu;

    always_comb begin
        grant_alu = ALU_VLD && (!RF_VLD || !last_alu);
        grant_rf  = RF_VLD && !grant_alu;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_alu <= 1'b0;
        end else if (take_alu) begin
            last_alu <= 1'b1;
        end else if (take_rf) begin
            last_alu <= 1'b0;
        end
    end
`else
    always_comb begin
        grant_alu = ALU_VLD;
        grant_rf  = RF_VLD && !ALU_VLD;
    end
`endif

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        take_alu   = 1'b0;
        take_rf    = 1'b0;
        WR_inc     = 1'b0;
        WR_DATA    = '0;
        case (state)
            IDLE: begin
                if (grant_alu) begin
                    take_alu   = 1'b1;
                    state_next = SEND_LO;
                end else if (grant_rf) begin
                    take_rf    = 1'b1;
                    state_next = SEND_RF;
                end
            end
            SEND_LO: begin
                WR_DATA = hold[DATA_WIDTH-1:0];
                if (!WR_full) begin
                    WR_inc     = 1'b1;
                    state_next = SEND_HI;
                end
            end
            SEND_HI: begin
                WR_DATA = hold[2*DATA_WIDTH-1:DATA_WIDTH];
                if (!WR_full) begin
                    WR_inc     = 1'b1;
                    state_next = IDLE;
                end
            end
            SEND_RF: begin
                WR_DATA = hold[DATA_WIDTH-1:0];
                if (!WR_full) begin
                    WR_inc     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, holding register and acknowledge pulses
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            hold    <= '0;
            ALU_ACK <= 1'b0;
            RF_ACK  <= 1'b0;
        end else begin
            state   <= state_next;
            ALU_ACK <= take_alu;
            RF_ACK  <= take_rf;
            if (take_alu) begin
                hold <= ALU_OUT;
            end else if (take_rf) begin
                // RF byte goes in the low half; the upper half is never sent.
                hold <= {{DATA_WIDTH{1'b0}}, RF_OUT};
            end
        end
    end

    assign BUSY      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_tx_fifo_wr_arb.sv
module tb_tx_fifo_wr_arb;

    localparam int W = 8;

    logic           CLK;
    logic           RST;
    logic           ALU_VLD;
    logic [2*W-1:0] ALU_OUT;
    logic           ALU_ACK;
    logic           RF_VLD;
    logic [W-1:0]   RF_OUT;
    logic           RF_ACK;
    logic           WR_full;
    logic           WR_inc;
    logic [W-1:0]   WR_DATA;
    logic           BUSY;
    logic [1:0]     dbg_state;

    int total;
    int bad;

    tx_fifo_wr_arb #(.DATA_WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ALU_VLD   (ALU_VLD),
        .ALU_OUT   (ALU_OUT),
        .ALU_ACK   (ALU_ACK),
        .RF_VLD    (RF_VLD),
        .RF_OUT    (RF_OUT),
        .RF_ACK    (RF_ACK),
        .WR_full   (WR_full),
        .WR_inc    (WR_inc),
        .WR_DATA   (WR_DATA),
        .BUSY      (BUSY),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1'b0;
        ALU_VLD = 1'b0; ALU_OUT = '0;
        RF_VLD = 1'b0;  RF_OUT = '0;
        WR_full = 1'b0;
        @(negedge CLK);
        total++;
        if ({ALU_ACK, RF_ACK, WR_inc, BUSY} !== 4'b0000 || WR_DATA !== 8'h00 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_outputs: ack=%b%b inc=%b busy=%b data=%h st=%0d, want all zero",
                     ALU_ACK, RF_ACK, WR_inc, BUSY, WR_DATA, dbg_state);
        end
        RST = 1'b1;
        @(negedge CLK);
        total++;
        if (BUSY !== 1'b0 || WR_inc !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: busy=%b inc=%b, want 0 0", BUSY, WR_inc);
        end
    endtask

    task automatic test_alu_basic();
        ALU_VLD = 1'b1; ALU_OUT = 16'hA55A;
        @(negedge CLK);
        total++;
        if (ALU_ACK !== 1'b1 || RF_ACK !== 1'b0 || WR_inc !== 1'b1 || WR_DATA !== 8'h5A || dbg_state !== 2'd1) begin
            bad++;
            $display("FAIL alu_lo: ack=%b inc=%b data=%h st=%0d, want 1 1 5a 1", ALU_ACK, WR_inc, WR_DATA, dbg_state);
        end
        ALU_VLD = 1'b0; ALU_OUT = 16'h0000;
        @(negedge CLK);
        total++;
        if (ALU_ACK !== 1'b0 || WR_inc !== 1'b1 || WR_DATA !== 8'hA5 || dbg_state !== 2'd2) begin
            bad++;
            $display("FAIL alu_hi: ack=%b inc=%b data=%h st=%0d, want 0 1 a5 2", ALU_ACK, WR_inc, WR_DATA, dbg_state);
        end
        @(negedge CLK);
        total++;
        if (BUSY !== 1'b0 || WR_inc !== 1'b0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL alu_done: busy=%b inc=%b st=%0d, want 0 0 0", BUSY, WR_inc, dbg_state);
        end
    endtask

    task automatic test_rf_full();
        WR_full = 1'b1;
        RF_VLD = 1'b1; RF_OUT = 8'h3C;
        @(negedge CLK);
        total++;
        if (RF_ACK !== 1'b1 || ALU_ACK !== 1'b0 || BUSY !== 1'b1 || dbg_state !== 2'd3) begin
            bad++;
            $display("FAIL rf_ack: rf_ack=%b alu_ack=%b busy=%b st=%0d, want 1 0 1 3", RF_ACK, ALU_ACK, BUSY, dbg_state);
        end
        RF_VLD = 1'b0; RF_OUT = 8'h00;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge CLK);
            total++;
            if (WR_inc !== 1'b0 || WR_DATA !== 8'h3C || (c > 0 && RF_ACK !== 1'b0)) begin
                bad++;
                $display("FAIL rf_stall c=%0d: inc=%b data=%h ack=%b, want 0 3c", c, WR_inc, WR_DATA, RF_ACK);
            end
        end
        WR_full = 1'b0;
        #1;
        total++;
        if (WR_inc !== 1'b1 || WR_DATA !== 8'h3C) begin
            bad++;
            $display("FAIL rf_release: inc=%b data=%h, want 1 3c", WR_inc, WR_DATA);
        end
        @(negedge CLK);
        total++;
        if (WR_inc !== 1'b0 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL rf_single_write: inc=%b busy=%b, want 0 0", WR_inc, BUSY);
        end
    endtask

    // Full rises while the low byte is pending, then again between bytes.
    task automatic test_full_mid();
        int writes;
        writes = 0;
        ALU_VLD = 1'b1; ALU_OUT = 16'hA55A;
        @(negedge CLK);
        ALU_VLD = 1'b0;
        WR_full = 1'b1;
        #1;
        total++;
        if (WR_inc !== 1'b0 || WR_DATA !== 8'h5A) begin
            bad++;
            $display("FAIL full_blocks_lo: inc=%b data=%h, want 0 5a", WR_inc, WR_DATA);
        end
        @(negedge CLK);
        WR_full = 1'b0;
        #1;
        if (WR_inc === 1'b1 && WR_DATA === 8'h5A) writes++;
        @(negedge CLK);
        WR_full = 1'b1;
        #1;
        total++;
        if (dbg_state !== 2'd2 || WR_inc !== 1'b0 || WR_DATA !== 8'hA5) begin
            bad++;
            $display("FAIL full_stall_hi: st=%0d inc=%b data=%h, want 2 0 a5", dbg_state, WR_inc, WR_DATA);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (WR_inc !== 1'b0) writes++;
        end
        WR_full = 1'b0;
        #1;
        if (WR_inc === 1'b1 && WR_DATA === 8'hA5) writes++;
        @(negedge CLK);
        if (WR_inc !== 1'b0) writes++;
        total++;
        if (writes !== 2 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL full_mid_count: writes=%0d busy=%b, want 2 0", writes, BUSY);
        end
    endtask

    task automatic test_tie();
        logic [2:0] exp_alu;
        int         to;
`ifdef TX_FIFO_WR_ARB_RR_EN
        exp_alu = 3'b101;  // ALU, RF, ALU
`else
        exp_alu = 3'b111;  // ALU every time
`endif
        do_reset();
        for (int k = 0; k < 3; k++) begin
            ALU_VLD = 1'b1; ALU_OUT = 16'h1234;
            RF_VLD  = 1'b1; RF_OUT  = 8'h77;
            @(negedge CLK);
            total++;
            if (ALU_ACK !== exp_alu[k] || RF_ACK !== !exp_alu[k] ||
                WR_DATA !== (exp_alu[k] ? 8'h34 : 8'h77)) begin
                bad++;
                $display("FAIL tie_%0d: alu_ack=%b rf_ack=%b data=%h, want alu_ack=%b", k, ALU_ACK, RF_ACK, WR_DATA, exp_alu[k]);
            end
            ALU_VLD = 1'b0; RF_VLD = 1'b0;
            to = 0;
            while (BUSY !== 1'b0 && to < 10) begin
                @(negedge CLK);
                to++;
            end
            if (to >= 10) begin
                total++;
                bad++;
                $display("FAIL tie_timeout_%0d: busy=%b, want 0", k, BUSY);
            end
        end
    endtask

    task automatic test_reset_mid();
        ALU_VLD = 1'b1; ALU_OUT = 16'hBEEF;
        @(negedge CLK);
        ALU_VLD = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        total++;
        if (dbg_state !== 2'd0 || BUSY !== 1'b0 || WR_inc !== 1'b0 || WR_DATA !== 8'h00 ||
            ALU_ACK !== 1'b0 || RF_ACK !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_async: st=%0d busy=%b inc=%b data=%h, want 0 0 0 00", dbg_state, BUSY, WR_inc, WR_DATA);
        end
        @(negedge CLK);
        RST = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            total++;
            if (WR_inc !== 1'b0 || BUSY !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_quiet c=%0d: inc=%b busy=%b, want 0 0", c, WR_inc, BUSY);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   exp_q[$];
        logic [2*W-1:0] alu_data;
        logic [W-1:0]   rf_data;
        logic [W-1:0]   exp_b;
        logic           alu_pend;
        logic           rf_pend;
        logic           alu_acked;
        logic           rf_acked;
        alu_pend = 1'b0; rf_pend = 1'b0;
        alu_data = '0;   rf_data = '0;
        do_reset();
        for (int i = 0; i < 10060; i++) begin
            @(negedge CLK);
            alu_acked = ALU_ACK;
            rf_acked  = RF_ACK;
            if (alu_acked && rf_acked) begin
                total++;
                bad++;
                $display("FAIL rnd_double_ack cycle=%0d", i);
            end
            if (alu_acked) begin
                if (!alu_pend) begin
                    total++; bad++;
                    $display("FAIL rnd_spurious_alu_ack cycle=%0d", i);
                end else begin
                    exp_q.push_back(alu_data[W-1:0]);
                    exp_q.push_back(alu_data[2*W-1:W]);
                end
                alu_pend = 1'b0; ALU_VLD = 1'b0;
            end
            if (rf_acked) begin
                if (!rf_pend) begin
                    total++; bad++;
                    $display("FAIL rnd_spurious_rf_ack cycle=%0d", i);
                end else begin
                    exp_q.push_back(rf_data);
                end
                rf_pend = 1'b0; RF_VLD = 1'b0;
            end
            if (i < 10000) begin
                if (!alu_pend && !alu_acked && $urandom_range(0, 2) == 0) begin
                    alu_data = 16'($urandom);
                    ALU_OUT = alu_data; ALU_VLD = 1'b1; alu_pend = 1'b1;
                end
                if (!rf_pend && !rf_acked && $urandom_range(0, 2) == 0) begin
                    rf_data = 8'($urandom);
                    RF_OUT = rf_data; RF_VLD = 1'b1; rf_pend = 1'b1;
                end
                WR_full = ($urandom_range(0, 3) == 0);
            end else begin
                WR_full = 1'b0;
            end
            #1;
            if (WR_inc === 1'b1 && WR_full === 1'b1) begin
                total++; bad++;
                $display("FAIL rnd_write_while_full cycle=%0d", i);
            end
            if (WR_inc === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rnd_extra_write cycle=%0d got=%h want none", i, WR_DATA);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (WR_DATA !== exp_b) begin
                        bad++;
                        $display("FAIL rnd_data cycle=%0d got=%h want=%h", i, WR_DATA, exp_b);
                    end
                end
            end
        end
        total++;
        if (exp_q.size() != 0 || alu_pend || rf_pend) begin
            bad++;
            $display("FAIL rnd_drain: left=%0d alu_pend=%b rf_pend=%b, want 0 0 0", exp_q.size(), alu_pend, rf_pend);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alu_basic();
        test_rf_full();
        test_full_mid();
        test_tie();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_fifo_wr_arb.md
# tx_fifo_wr_arb

Write-side scheduler for the asynchronous TX FIFO. Accepts byte streams from two requesters in the system-clock domain (16-bit ALU result, 8-bit register-file read data), arbitrates between them, and serialises their bytes into the FIFO write port (`WR_inc`/`WR_DATA`), stalling whenever the FIFO reports `WR_full`. It sits between the system controller datapath and the FIFO write-pointer logic, on the same clock as the FIFO write side.

## Interface
- `DATA_WIDTH`, 8: FIFO word width; ALU result is `2*DATA_WIDTH`.
- `CLK` input 1: system/FIFO write clock.
- `RST` input 1: asynchronous, active-low reset.
- `ALU_VLD` input 1: ALU result request.
- `ALU_OUT` input 2*DATA_WIDTH: ALU result; sent low byte first.
- `ALU_ACK` output 1: one-cycle pulse, ALU request captured.
- `RF_VLD` input 1: register-file read-data request.
- `RF_OUT` input DATA_WIDTH: register-file byte.
- `RF_ACK` output 1: one-cycle pulse, RF request captured.
- `WR_full` input 1: FIFO full flag from the write-pointer block.
- `WR_inc` output 1: FIFO write strobe.
- `WR_DATA` output DATA_WIDTH: FIFO write data.
- `BUSY` output 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, SEND_LO, SEND_HI, SEND_RF.
- IDLE: if any `*_VLD` is high, grant one requester at the clock edge; latch its data into a `2*DATA_WIDTH` holding register; pulse the matching ACK for the next cycle. ALU grant goes to SEND_LO. RF grant goes to SEND_RF.
- Requests are sampled only in IDLE. A requester holds VLD and data until it sees ACK, and drops VLD the cycle after ACK.
- SEND_LO: `WR_DATA` = hold[7:0]. When `!WR_full`, `WR_inc`=1 and the state moves to SEND_HI. Otherwise the state holds.
- SEND_HI: `WR_DATA` = hold[15:8]. When `!WR_full`, write and move to IDLE.
- SEND_RF: `WR_DATA` = hold[7:0]. When `!WR_full`, write and move to IDLE.
- `WR_inc` = (state ≠ IDLE) && !`WR_full`, combinational. Exactly one FIFO write per byte; no write is ever issued while `WR_full`=1.
- `WR_DATA` is driven from the holding register by a state mux and is stable for every cycle the state holds.
- The two ALU bytes are always written back-to-back, with no RF byte interleaved.
- Reset values: state=IDLE, hold=0, `ALU_ACK`=`RF_ACK`=0, `WR_inc`=0, `WR_DATA`=0, `BUSY`=0, last-grant register=RF. Reset mid-transfer discards the held bytes and issues no further writes.

## Timing
- Request present at edge t (IDLE) → ACK high during cycle t+1. First `WR_inc` in cycle t+1 if not full.
- Minimum occupancy: ALU 2 cycles, RF 1 cycle; then 1 cycle in IDLE before the next grant.
- Peak throughput: 2 bytes per 3 cycles (ALU), 1 byte per 2 cycles (RF).
- `WR_full` rising in the same cycle as a pending byte blocks that write. The byte is written in the first cycle `WR_full` is low.
- Both VLD high in IDLE: the arbitration rule (Configuration) decides; the loser waits in IDLE for the next pass.

## Configuration
- `TX_FIFO_WR_ARB_RR_EN` defined: round-robin arbitration. On a simultaneous request, the requester not granted last wins. The last-grant register updates on every grant and resets to RF, so ALU wins the first tie.
- Undefined: fixed priority, ALU always wins a tie. The last-grant register is not instantiated.

## Test plan
- Reset, idle FIFO; `ALU_VLD`, `ALU_OUT`=16'hA55A → `ALU_ACK` one cycle; writes 8'h5A then 8'hA5 on consecutive cycles; `BUSY` low the cycle after.
- `RF_VLD`, `RF_OUT`=8'h3C with `WR_full`=1 for 5 cycles → `WR_inc` stays 0 and `WR_DATA` holds 8'h3C; exactly one write in the cycle `WR_full` drops.
- `WR_full` asserted between the ALU low and high bytes → 8'h5A written, stall in SEND_HI, then 8'hA5; no duplicate or missing write.
- Both VLD high together three times, with the RR macro defined → grant order ALU, RF, ALU. Macro undefined → ALU every time.
- `RST` low during SEND_HI → outputs return to reset values asynchronously; after release, no write occurs until a new request arrives.
- Random back-to-back requests with random `WR_full` for 10k cycles → the FIFO byte stream matches a scoreboard of granted requests, and there are zero writes while full.
